// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit for the 5-stage MIPS pipeline.
// Forwarding selects are combinational; load-use stalls run from a small FSM
// that holds the pipeline for LOAD_LAT cycles per episode and counts episodes.
// Optional macro FWD_WB_BYPASS_EN enables decode-stage write-through selects.
module fwd_hazard_unit #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned LOAD_LAT   = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_ExM_RegWrite,
  input  logic                  in_MW_RegWrite,
  input  logic [REG_ADDR_W-1:0] in_ExM_RegisterRd,
  input  logic [REG_ADDR_W-1:0] in_MW_RegisterRd,
  input  logic [REG_ADDR_W-1:0] in_IdEx_RegisterRs,
  input  logic [REG_ADDR_W-1:0] in_IdEx_RegisterRt,
  input  logic                  in_IdEx_MemRead,
  input  logic [REG_ADDR_W-1:0] in_IfId_RegisterRs,
  input  logic [REG_ADDR_W-1:0] in_IfId_RegisterRt,
  input  logic                  in_IfId_UsesRt,
  input  logic                  in_Flush,
  output logic [1:0]            ForwardA,
  output logic [1:0]            ForwardB,
  output logic                  Stall,
  output logic                  Bubble,
  output logic [CNT_W-1:0]      StallCount,
  output logic                  BypassA,
  output logic                  BypassB
);

  localparam int unsigned LatW = ($clog2(LOAD_LAT + 1) < 1) ? 1 : $clog2(LOAD_LAT + 1);
  localparam logic [LatW-1:0] LatInit = LatW'(LOAD_LAT - 1);
  localparam logic [LatW-1:0] LatOne  = LatW'(1);

  typedef enum logic [0:0] {StIdle, StStall} state_e;

  state_e           state_q, state_d;
  logic [LatW-1:0]  lat_q, lat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hz;
  logic             stallRaw;

  logic exmHit, mwHitA, mwHitB, exmHitB;

  // EX/MEM and MEM/WB match terms; register 0 never forwards.
  always_comb begin
    exmHit  = in_ExM_RegWrite & (in_ExM_RegisterRd != '0) &
              (in_ExM_RegisterRd == in_IdEx_RegisterRs);
    exmHitB = in_ExM_RegWrite & (in_ExM_RegisterRd != '0) &
              (in_ExM_RegisterRd == in_IdEx_RegisterRt);
    mwHitA  = in_MW_RegWrite & (in_MW_RegisterRd != '0) &
              (in_MW_RegisterRd == in_IdEx_RegisterRs);
    mwHitB  = in_MW_RegWrite & (in_MW_RegisterRd != '0) &
              (in_MW_RegisterRd == in_IdEx_RegisterRt);
  end

  // Operand select: EX/MEM holds the youngest value, so it wins over MEM/WB.
  always_comb begin
    ForwardA = 2'b00;
    ForwardB = 2'b00;
    if (exmHit)      ForwardA = 2'b10;
    else if (mwHitA) ForwardA = 2'b01;
    if (exmHitB)     ForwardB = 2'b10;
    else if (mwHitB) ForwardB = 2'b01;
  end

  // Load in EX whose destination feeds the instruction now in decode.
  assign hz = in_IdEx_MemRead & (in_IdEx_RegisterRt != '0) &
              ((in_IdEx_RegisterRt == in_IfId_RegisterRs) |
               (in_IfId_UsesRt & (in_IdEx_RegisterRt == in_IfId_RegisterRt)));

  // Stall FSM next state, latency countdown and saturating episode counter.
  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    cnt_d    = cnt_q;
    stallRaw = 1'b0;
    if (in_Flush) begin
      state_d = StIdle;
      lat_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (hz) begin
            stallRaw = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
            if (LOAD_LAT > 1) begin
              state_d = StStall;
              lat_d   = LatInit;
            end
          end
        end
        StStall: begin
          // Hazards seen here belong to the episode already being served.
          stallRaw = 1'b1;
          lat_d    = lat_q - LatOne;
          if (lat_q == LatOne) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Reset masks the combinational detection path so no bubble leaks out.
  always_comb begin
    Stall  = stallRaw & ~reset;
    Bubble = stallRaw & ~reset;
  end

  assign StallCount = cnt_q;

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      lat_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef FWD_WB_BYPASS_EN
  // Write-through for a register file that does not write before read.
  assign BypassA = in_MW_RegWrite & (in_MW_RegisterRd != '0) &
                   (in_MW_RegisterRd == in_IfId_RegisterRs);
  assign BypassB = in_MW_RegWrite & in_IfId_UsesRt & (in_MW_RegisterRd != '0) &
                   (in_MW_RegisterRd == in_IfId_RegisterRt);
`else
  assign BypassA = 1'b0;
  assign BypassB = 1'b0;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: two instances (LOAD_LAT=1 with a wide
// counter, LOAD_LAT=3 with a 2-bit counter) share stimulus and are compared
// against a remaining-stall-cycles model.
module tb_fwd_hazard_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       exWr, mwWr, memRead, usesRt, flush;
  logic [4:0] exRd, mwRd, idExRs, idExRt, ifIdRs, ifIdRt;

  logic [1:0]  fa1, fb1, fa3, fb3;
  logic        st1, bu1, st3, bu3, ba1, bb1, ba3, bb3;
  logic [15:0] sc1;
  logic [1:0]  sc3;

  int nVec = 0;
  int nChecks = 0;
  int nMis = 0;

  // Model: stall cycles still owed after the current one, and episode counts.
  int left1, left3, cnt1, cnt3;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.REG_ADDR_W(5), .LOAD_LAT(1), .CNT_W(16)) u1 (
    .clk(clk), .reset(reset),
    .in_ExM_RegWrite(exWr), .in_MW_RegWrite(mwWr),
    .in_ExM_RegisterRd(exRd), .in_MW_RegisterRd(mwRd),
    .in_IdEx_RegisterRs(idExRs), .in_IdEx_RegisterRt(idExRt),
    .in_IdEx_MemRead(memRead),
    .in_IfId_RegisterRs(ifIdRs), .in_IfId_RegisterRt(ifIdRt),
    .in_IfId_UsesRt(usesRt), .in_Flush(flush),
    .ForwardA(fa1), .ForwardB(fb1), .Stall(st1), .Bubble(bu1),
    .StallCount(sc1), .BypassA(ba1), .BypassB(bb1)
  );

  fwd_hazard_unit #(.REG_ADDR_W(5), .LOAD_LAT(3), .CNT_W(2)) u3 (
    .clk(clk), .reset(reset),
    .in_ExM_RegWrite(exWr), .in_MW_RegWrite(mwWr),
    .in_ExM_RegisterRd(exRd), .in_MW_RegisterRd(mwRd),
    .in_IdEx_RegisterRs(idExRs), .in_IdEx_RegisterRt(idExRt),
    .in_IdEx_MemRead(memRead),
    .in_IfId_RegisterRs(ifIdRs), .in_IfId_RegisterRt(ifIdRt),
    .in_IfId_UsesRt(usesRt), .in_Flush(flush),
    .ForwardA(fa3), .ForwardB(fb3), .Stall(st3), .Bubble(bu3),
    .StallCount(sc3), .BypassA(ba3), .BypassB(bb3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nMis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] expFwd(input logic [4:0] src);
    if (exWr && exRd != 5'd0 && exRd == src) return 2'b10;
    if (mwWr && mwRd != 5'd0 && mwRd == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic expHz();
    return memRead && idExRt != 5'd0 &&
           (idExRt == ifIdRs || (usesRt && idExRt == ifIdRt));
  endfunction

  function automatic logic expStall(input int left);
    if (reset || flush) return 1'b0;
    if (left > 0) return 1'b1;
    return expHz();
  endfunction

  function automatic logic expBypA();
`ifdef FWD_WB_BYPASS_EN
    return mwWr && mwRd != 5'd0 && mwRd == ifIdRs;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic expBypB();
`ifdef FWD_WB_BYPASS_EN
    return mwWr && usesRt && mwRd != 5'd0 && mwRd == ifIdRt;
`else
    return 1'b0;
`endif
  endfunction

  task automatic checkAll();
    #2;
    chk("u1.ForwardA", 32'(fa1), 32'(expFwd(idExRs)));
    chk("u1.ForwardB", 32'(fb1), 32'(expFwd(idExRt)));
    chk("u3.ForwardA", 32'(fa3), 32'(expFwd(idExRs)));
    chk("u3.ForwardB", 32'(fb3), 32'(expFwd(idExRt)));
    chk("u1.Stall", 32'(st1), 32'(expStall(left1)));
    chk("u1.Bubble", 32'(bu1), 32'(expStall(left1)));
    chk("u3.Stall", 32'(st3), 32'(expStall(left3)));
    chk("u3.Bubble", 32'(bu3), 32'(expStall(left3)));
    chk("u1.StallCount", 32'(sc1), 32'(cnt1));
    chk("u3.StallCount", 32'(sc3), 32'(cnt3));
    chk("u1.BypassA", 32'(ba1), 32'(expBypA()));
    chk("u1.BypassB", 32'(bb1), 32'(expBypB()));
    chk("u3.BypassA", 32'(ba3), 32'(expBypA()));
    chk("u3.BypassB", 32'(bb3), 32'(expBypB()));
  endtask

  // Advance one instance's model across a clock edge.
  task automatic modelEdge(input int lat, input int maxCnt, inout int left, inout int cnt);
    if (flush) left = 0;
    else if (left > 0) left = left - 1;
    else if (expHz()) begin
      if (cnt < maxCnt) cnt = cnt + 1;
      left = lat - 1;
    end
  endtask

  task automatic step();
    nVec++;
    checkAll();
    modelEdge(1, 65535, left1, cnt1);
    modelEdge(3, 3, left3, cnt3);
    @(posedge clk);
    #1;
  endtask

  task automatic modelReset();
    left1 = 0; left3 = 0; cnt1 = 0; cnt3 = 0;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic resetPulse();
    reset = 1'b1;
    #1;
    modelReset();
    checkAll();
    reset = 1'b0;
  endtask

  task automatic clr();
    exWr = 0; mwWr = 0; memRead = 0; usesRt = 0; flush = 0;
    exRd = 0; mwRd = 0; idExRs = 0; idExRt = 0; ifIdRs = 0; ifIdRt = 0;
  endtask

  task automatic setLoadHazard();
    clr();
    memRead = 1; idExRt = 5'd5; ifIdRs = 5'd5;
  endtask

  initial begin
    clr();
    modelReset();
    reset = 1'b1;
    #1;
    checkAll();
    chk("reset.u3.Stall", 32'(st3), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // EX/MEM wins over MEM/WB on the same source.
    clr();
    exWr = 1; exRd = 5'd8; mwWr = 1; mwRd = 5'd8; idExRs = 5'd8; idExRt = 5'd9;
    #1;
    chk("fwd.prioA", 32'(fa1), 32'h2);
    chk("fwd.prioB", 32'(fb1), 32'h0);
    step();

    // Register 0 never forwards.
    clr();
    exWr = 1; mwWr = 1;
    #1;
    chk("fwd.zeroA", 32'(fa3), 32'h0);
    step();

    // Single load-use hazard.
    setLoadHazard();
    #1;
    chk("hz.u1.Stall", 32'(st1), 32'h1);
    step();
    clr();
    for (int i = 0; i < 4; i++) step();
    chk("hz.u1.count", 32'(sc1), 32'd1);
    chk("hz.u3.count", 32'(sc3), 32'd1);

    // Hazard held through the stall is not re-counted by the LOAD_LAT=3 unit.
    setLoadHazard();
    for (int i = 0; i < 3; i++) step();
    clr();
    for (int i = 0; i < 3; i++) step();

    // Flush in the second stall cycle.
    setLoadHazard();
    step();
    clr();
    flush = 1;
    step();
    flush = 0;
    for (int i = 0; i < 2; i++) step();

    // Reset in the middle of a stall.
    setLoadHazard();
    step();
    clr();
    resetPulse();
    chk("rst.u3.count", 32'(sc3), 32'd0);
    for (int i = 0; i < 3; i++) step();

    // Five separate episodes saturate the 2-bit counter.
    for (int e = 0; e < 5; e++) begin
      setLoadHazard();
      step();
      clr();
      for (int i = 0; i < 3; i++) step();
    end
    chk("sat.u3.count", 32'(sc3), 32'd3);
    chk("sat.u1.count", 32'(sc1), 32'd5);

    // Decode-stage bypass gated by UsesRt.
    clr();
    mwWr = 1; mwRd = 5'd7; ifIdRt = 5'd7; usesRt = 0;
    step();
    usesRt = 1;
    #1;
`ifdef FWD_WB_BYPASS_EN
    chk("byp.B", 32'(bb1), 32'd1);
`else
    chk("byp.B", 32'(bb1), 32'd0);
`endif
    step();

    // Randomized traffic with small register numbers to provoke matches.
    for (int n = 0; n < 400; n++) begin
      exWr    = 1'($urandom_range(1));
      mwWr    = 1'($urandom_range(1));
      memRead = 1'($urandom_range(1));
      usesRt  = 1'($urandom_range(1));
      flush   = ($urandom_range(7) == 0);
      exRd    = 5'($urandom_range(3));
      mwRd    = 5'($urandom_range(3));
      idExRs  = 5'($urandom_range(3));
      idExRt  = 5'($urandom_range(3));
      ifIdRs  = 5'($urandom_range(3));
      ifIdRt  = 5'($urandom_range(3));
      if ($urandom_range(59) == 0) resetPulse();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
